// File: rtl/sam_pkg.sv
// sam_pkg: shared state encoding and field widths for the SAM configuration loader.
package sam_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_SEND_N,
      S_SEND_D,
      S_SEND_CN,
      S_TRAIL
   } sam_cfg_state_t;
   localparam int SAM_N_W       = 4;
   localparam int SAM_CNT_W     = 16;
   localparam int SAM_LEAD_CYC  = 1;
   localparam int SAM_TRAIL_CYC = 1;
endpackage

// File: rtl/sam_cfg_piso.sv
// sam_cfg_piso: MSB-first parallel-in/serial-out register with registered output, idles at 1.
module sam_cfg_piso #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         q
);
   logic [W-1:0] sr;
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q  <= 1'b1;
         sr <= '1;
      end else if (load) begin
         {q, sr} <= {din, 1'b1};
      end else if (shift) begin
         {q, sr} <= {sr, 1'b1};
      end
   end
endmodule

// File: rtl/sam_cfg_loader.sv
// sam_cfg_loader: serialises (n, d, capsN) onto SAM str/mode pins, MSB first.
// Optional SAM_CFG_ABORT_EN adds an abort input that terminates a transfer with err.
module sam_cfg_loader
   import sam_pkg::*;
#(
   parameter int MAX_KEY_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
`ifdef SAM_CFG_ABORT_EN
   input  logic                 abort,
`endif
   input  logic                 start,
   input  logic [3:0]           n_in,
   input  logic [MAX_KEY_W-1:0] d_in,
   input  logic [MAX_KEY_W-1:0] capsn_in,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic                 str,
   output logic                 mode
);
   localparam int PW   = MAX_KEY_W > SAM_N_W ? MAX_KEY_W : SAM_N_W;
   localparam int LOGW = $clog2(MAX_KEY_W);
   sam_cfg_state_t         state;
   logic [SAM_CNT_W-1:0]   cnt;
   logic [SAM_N_W-1:0]     n_r;
   logic [MAX_KEY_W-1:0]   d_r;
   logic [MAX_KEY_W-1:0]   cn_r;
   logic [SAM_CNT_W-1:0]   k_m1;
   logic [PW-1:0]          n_just;
   logic [PW-1:0]          d_just;
   logic [PW-1:0]          cn_just;
   logic [PW-1:0]          piso_din;
   logic                   last;
   logic                   abort_hit;
   logic                   piso_clr;
   logic                   piso_load;
   logic                   piso_shift;
`ifdef SAM_CFG_ABORT_EN
   assign abort_hit = abort && busy;
`else
   assign abort_hit = 1'b0;
`endif
   assign busy       = ~ready;
   assign last       = cnt == '0;
   assign k_m1       = SAM_CNT_W'((32'd1 << n_r) - 32'd1);
   // fields are left-justified so the PISO always emits from its top bit
   assign n_just     = PW'(n_r) << (PW - SAM_N_W);
   assign d_just     = PW'(d_r) << (PW - (32'd1 << n_r));
   assign cn_just    = PW'(cn_r) << (PW - (32'd1 << n_r));
   assign piso_din   = state == S_LEAD ? n_just : state == S_SEND_N ? d_just : cn_just;
   assign piso_clr   = abort_hit || state == S_IDLE || state == S_TRAIL || (state == S_SEND_CN && last);
   assign piso_load  = state == S_LEAD || ((state == S_SEND_N || state == S_SEND_D) && last);
   assign piso_shift = (state == S_SEND_N || state == S_SEND_D || state == S_SEND_CN) && !last;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         ready <= 1'b1;
         done  <= 1'b0;
         err   <= 1'b0;
         mode  <= 1'b0;
         cnt   <= '0;
         n_r   <= '0;
         d_r   <= '0;
         cn_r  <= '0;
      end else if (abort_hit) begin
         state <= S_IDLE;
         ready <= 1'b1;
         done  <= 1'b0;
         err   <= 1'b1;
         mode  <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               if (32'(n_in) > LOGW) err <= 1'b1;
               else begin
                  n_r   <= n_in;
                  d_r   <= d_in;
                  cn_r  <= capsn_in;
                  state <= S_LEAD;
                  mode  <= 1'b1;
                  ready <= 1'b0;
               end
            end
            S_LEAD: begin
               state <= S_SEND_N;
               cnt   <= SAM_CNT_W'(SAM_N_W - 1);
            end
            S_SEND_N: begin
               state <= last ? S_SEND_D : S_SEND_N;
               cnt   <= last ? k_m1 : cnt - 1'b1;
            end
            S_SEND_D: begin
               state <= last ? S_SEND_CN : S_SEND_D;
               cnt   <= last ? k_m1 : cnt - 1'b1;
            end
            S_SEND_CN: begin
               state <= last ? S_TRAIL : S_SEND_CN;
               cnt   <= last ? cnt : cnt - 1'b1;
            end
            S_TRAIL: begin
               state <= S_IDLE;
               mode  <= 1'b0;
               ready <= 1'b1;
               done  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
   sam_cfg_piso #(.W(PW)) u_piso (
      .clk   (clk),
      .reset (reset),
      .clr   (piso_clr),
      .load  (piso_load),
      .shift (piso_shift),
      .din   (piso_din),
      .q     (str)
   );
endmodule

// File: doc/sam_cfg_loader.md
# sam_cfg_loader

Configuration sequencer for the SAM decryption block. Accepts a parallel key set (n, d, capsN) through a start/ready handshake and serialises it onto SAM's `str`/`mode` configuration pins, MSB first, one bit per clock. It raises `mode` for the whole transfer and drops it afterwards. Sits between the host register file and the SAM instance, and replaces hand-driven configuration.

## Interface
- `MAX_KEY_W`, default 16: widest supported key length; must be a power of two, at most 2^15.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request to load; sampled only when `ready`=1.
- `n_in`  in  4: key exponent; key length K = 2^n.
- `d_in`  in  MAX_KEY_W: private exponent d, LSB-aligned; bits [K-1:0] used.
- `capsn_in`  in  MAX_KEY_W: modulus capsN, LSB-aligned; bits [K-1:0] used.
- `ready`  out  1: idle, accepting `start`.
- `busy`  out  1: transfer in progress.
- `done`  out  1: one-cycle pulse on successful completion.
- `err`  out  1: one-cycle pulse when a request is rejected.
- `str`  out  1: serial configuration data to SAM.
- `mode`  out  1: SAM configuration-mode strobe.

## Operation
- Reset values: `ready`=1, `busy`=0, `done`=0, `err`=0, `str`=1, `mode`=0; FSM in IDLE.
- On `start`&`ready`:
  - `n_in`, `d_in` and `capsn_in` are captured into internal registers.
  - Later changes on these inputs have no effect.
- Range check: if 2^`n_in` > `MAX_KEY_W`, the request is rejected.
  - `err` pulses for one cycle.
  - `mode` stays 0 and the FSM stays in IDLE.
- FSM states: IDLE → LEAD → SEND_N → SEND_D → SEND_CN → TRAIL → IDLE.
- LEAD, 1 cycle: `mode`=1, `str`=1. This is the unmodelled edge before n.
- SEND_N, 4 cycles: `str` = n[3], n[2], n[1], n[0].
- SEND_D, K cycles: `str` = d[K-1] … d[0].
- SEND_CN, K cycles: `str` = capsN[K-1] … capsN[0].
- TRAIL, 1 cycle: `mode`=1, `str`=1. This is the edge after the last capsN bit.
- Return to IDLE: `mode`=0, `str`=1, `done` pulses for one cycle.
- `busy` = NOT `ready`. `start` while busy is ignored; it is not queued.
- Bit counter is 16 bits wide. It loads K−1 on entry to SEND_D and again on entry to SEND_CN. The state advances when the counter reaches 0.
- n=0 gives K=1: one bit of d and one bit of capsN.

## Timing
- Accept edge is cycle 0; `ready` falls and `mode` rises in cycle 1 (LEAD).
- `mode` stays high for exactly 2K+6 cycles; for n=3 that is 22 cycles.
- `str` and `mode` are registered and change on the rising edge. SAM samples them on its next rising edge.
- `done` is asserted in the cycle `mode` returns to 0. `ready`=1 in that same cycle, so back-to-back `start` is legal: `mode` re-rises one cycle after the new accept.
- `err` is asserted the cycle after the rejected `start`; `ready` stays 1 throughout.
- `reset` during a transfer: at that edge all outputs take their reset values, `mode` drops immediately and no `done` is produced.
- `reset` and `start` in the same cycle: reset wins and the request is lost.

## Configuration
- `SAM_CFG_ABORT_EN` defined: adds input `abort` (1 bit).
  - `abort`=1 while busy drops `mode` and sets `str`=1 on the next edge.
  - The FSM returns to IDLE and `err` pulses; no `done` is produced.
  - `abort` while idle is ignored.
- Not defined: no `abort` port; a transfer can only be terminated by `reset`.

## Structure
- Package `sam_pkg` holds:
  - state enum `sam_cfg_state_t`;
  - `SAM_N_W`=4 and `SAM_CNT_W`=16;
  - `SAM_LEAD_CYC`=1 and `SAM_TRAIL_CYC`=1.
- Sub-module `sam_cfg_piso`: MSB-first parallel-in/serial-out shift register with a `load` and `shift` enable, idle output 1. It is instantiated once. The FSM reloads it per field (n, d, capsN) with the field left-justified.

## Test plan
- n=3, d=8'hA5, capsN=8'h3C: `str` over the 22 mode-high cycles must be 1, 0011, 10100101, 00111100, 1. Then `mode`=0 and `done` pulses once.
- n=4 with MAX_KEY_W=16, d=16'h8001, capsN=16'hFFFE: `mode` is high for 38 cycles; the first d bit is 1 and the last capsN bit is 0.
- n=5 with MAX_KEY_W=16: `err` pulses, `mode` never rises, `ready` stays 1.
- `reset` asserted 10 cycles after an n=3 accept: `mode`=0, `str`=1 and `ready`=1 at the next edge, with no `done`. A following n=0 load (d=1, capsN=0) gives `str` = 1, 0000, 1, 0, 1 over 8 cycles.
- `start` held high continuously for two loads: the second accept lands in the `done` cycle, and `mode` drops for exactly one cycle between the transfers.
- With `SAM_CFG_ABORT_EN`: `abort` in SEND_D causes `mode` to fall at the next edge and `err` to pulse once, with no `done`.
